axi_dma_sram_responder: RTL

AXI4 burst slave that answers the JPEG decoder's DMA master, which issues INCR bursts on a 32-bit data, 4-bit ID bus. Backs the bus with a single-port synchronous SRAM that has 1-cycle read latency. Used as on-chip frame/bitstream memory and as the bench-side memory model for the decoder subsystem. Serves one transaction at a time; reads sustain 1 beat/cycle.

---
 rtl/axi_dma_pkg.sv | 13 +
 rtl/axi_dma_rd_fifo.sv | 33 +++
 rtl/axi_dma_sram_responder.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/axi_dma_pkg.sv
// axi_dma_pkg: burst/response encodings, FSM states and read-FIFO beat type for the DMA SRAM responder
package axi_dma_pkg;
    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    typedef enum logic [1:0] {IDLE, WDATA, WRESP, RD} state_t;
    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } rd_beat_t;
endpackage

// File: rtl/axi_dma_rd_fifo.sv
// axi_dma_rd_fifo: two-entry read-data FIFO carrying the last flag alongside each word
module axi_dma_rd_fifo
    import axi_dma_pkg::*;
(
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       push,
    input  logic       pop,
    input  rd_beat_t   wr_beat,
    output rd_beat_t   head,
    output logic [1:0] count
);
    rd_beat_t slot [2];
    logic wr_ptr, rd_ptr;
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            slot[0] <= '0;
            slot[1] <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
        end else begin
            if (push) begin
                slot[wr_ptr] <= wr_beat;
                wr_ptr       <= !wr_ptr;
            end
            if (pop)
                rd_ptr <= !rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end
    assign head = slot[rd_ptr];
endmodule

// File: rtl/axi_dma_sram_responder.sv
// axi_dma_sram_responder: single-transaction AXI4 burst slave in front of a 1-cycle-latency single-port SRAM
module axi_dma_sram_responder
    import axi_dma_pkg::*;
#(
    parameter int ID_WIDTH   = 4,
    parameter int MEM_AW     = 14,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  aw_valid,
    output logic                  aw_ready,
    input  logic [ADDR_WIDTH-1:0] aw_addr,
    input  logic [ID_WIDTH-1:0]   aw_id,
    input  logic [7:0]            aw_len,
    input  logic [1:0]            aw_burst,
    input  logic                  w_valid,
    output logic                  w_ready,
    input  logic [31:0]           w_data,
    input  logic [3:0]            w_strb,
    input  logic                  w_last,
    output logic                  b_valid,
    input  logic                  b_ready,
    output logic [1:0]            b_resp,
    output logic [ID_WIDTH-1:0]   b_id,
    input  logic                  ar_valid,
    output logic                  ar_ready,
    input  logic [ADDR_WIDTH-1:0] ar_addr,
    input  logic [ID_WIDTH-1:0]   ar_id,
    input  logic [7:0]            ar_len,
    input  logic [1:0]            ar_burst,
    output logic                  r_valid,
    input  logic                  r_ready,
    output logic [31:0]           r_data,
    output logic [1:0]            r_resp,
    output logic [ID_WIDTH-1:0]   r_id,
    output logic                  r_last,
    output logic                  mem_en,
    output logic [3:0]            mem_we,
    output logic [MEM_AW-1:0]     mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);
    state_t              state, state_nx;
    logic [MEM_AW-1:0]   addr;
    logic [7:0]          len, cnt;
    logic [8:0]          issued;
    logic [1:0]          burst;
    logic [ID_WIDTH-1:0] id;
    logic                err, prefer_w, inflight, inflight_last;
    logic                aw_hs, ar_hs, w_hs, pop, issue, pick, grant_w;
    logic [1:0]          fifo_count;
    rd_beat_t            head;
    logic                unused_addr;

    assign unused_addr = ^{aw_addr[ADDR_WIDTH-1:MEM_AW+2], aw_addr[1:0], ar_addr[ADDR_WIDTH-1:MEM_AW+2], ar_addr[1:0]};
    assign aw_hs   = aw_valid && aw_ready;
    assign ar_hs   = ar_valid && ar_ready;
    assign pick    = state == IDLE && !aw_ready && !ar_ready;
    assign grant_w = aw_valid && (!ar_valid || prefer_w);

    axi_dma_rd_fifo u_fifo (
        .aclk    (aclk),
        .aresetn (aresetn),
        .push    (inflight),
        .pop     (pop),
        .wr_beat ({mem_rdata, inflight_last}),
        .head    (head),
        .count   (fifo_count)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = aw_hs ? WDATA : ar_hs ? RD : IDLE;
            WDATA:   state_nx = (w_hs && cnt == len) ? WRESP : WDATA;
            WRESP:   state_nx = b_ready ? IDLE : WRESP;
            RD:      state_nx = (pop && head.last) ? IDLE : RD;
            default: state_nx = IDLE;
        endcase
    end

    // A beat popped this cycle frees its slot in time for a read issued now, keeping 1 beat/cycle.
    always_comb begin
        w_ready   = state == WDATA;
        w_hs      = w_valid && w_ready;
        b_valid   = state == WRESP;
        b_resp    = (b_valid && err) ? RESP_SLVERR : RESP_OKAY;
        b_id      = id;
        r_valid   = state == RD && fifo_count != 2'd0;
        pop       = r_valid && r_ready;
        r_data    = (r_valid && !err) ? head.data : 32'd0;
        r_resp    = (r_valid && err) ? RESP_SLVERR : RESP_OKAY;
        r_id      = id;
        r_last    = r_valid && head.last;
        issue     = state == RD && issued <= {1'b0, len} && (3'(fifo_count) + 3'(inflight) - 3'(pop)) < 3'd2;
        mem_en    = w_hs || issue;
        mem_we    = (w_hs && !err) ? w_strb : 4'd0;
        mem_addr  = addr;
        mem_wdata = w_hs ? w_data : 32'd0;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_ready      <= 1'b0;
            ar_ready      <= 1'b0;
            prefer_w      <= 1'b1;
            addr          <= '0;
            len           <= 8'd0;
            cnt           <= 8'd0;
            issued        <= 9'd0;
            burst         <= 2'd0;
            id            <= '0;
            err           <= 1'b0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            aw_ready <= pick && grant_w;
            ar_ready <= pick && !grant_w && ar_valid;
            if (pick && aw_valid && ar_valid)
                prefer_w <= !prefer_w;
            inflight <= issue;
            if (issue)
                inflight_last <= issued[7:0] == len;
            if (aw_hs || ar_hs) begin
                addr   <= aw_hs ? aw_addr[MEM_AW+1:2] : ar_addr[MEM_AW+1:2];
                len    <= aw_hs ? aw_len : ar_len;
                id     <= aw_hs ? aw_id : ar_id;
                burst  <= aw_hs ? aw_burst : ar_burst;
                err    <= (aw_hs ? aw_burst : ar_burst) >= BURST_WRAP;
                cnt    <= 8'd0;
                issued <= 9'd0;
            end else begin
                if (w_hs || issue)
                    addr <= burst == BURST_INCR ? addr + MEM_AW'(1) : addr;
                if (w_hs) begin
                    cnt <= cnt + 8'd1;
                    if (w_last != (cnt == len))
                        err <= 1'b1;
                end
                if (issue)
                    issued <= issued + 9'd1;
            end
        end
    end
endmodule
